// File: rtl/vec_stream_io.sv
// vec_stream_io: count-framed adapter between an XW-channel vector and a
// stream of QW-bit network words. TX serializes channels 0..valid_chans-1 of
// an accepted vector; RX collects valid_chans words and presents them as one
// vector. The two paths share only the clock and reset.
module vec_stream_io #(
   parameter int QW          = 32,
   parameter int XW          = 128,
   parameter int valid_chans = 128
) (
   input  logic                  clk_nw,
   input  logic                  rstn_nw,
   // TX: vector in, words out
   input  logic [XW-1:0][QW-1:0] vec_data_i,
   input  logic                  vec_valid_i,
   output logic                  vec_ready_o,
   output logic [QW-1:0]         nw_data_o,
   output logic                  nw_valid_o,
   input  logic                  nw_ready_i,
   // RX: words in, vector out
   input  logic [QW-1:0]         nw_data_i,
   input  logic                  nw_valid_i,
   output logic                  nw_ready_o,
   output logic [XW-1:0][QW-1:0] vec_data_o,
   output logic                  vec_valid_o,
   input  logic                  vec_ready_i
);

   localparam int            CW   = (XW > 1) ? $clog2(XW) : 1;
   // Index of the final word of a frame; both counters stop here.
   localparam logic [CW-1:0] LAST = CW'(valid_chans - 1);

   typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
   typedef enum logic {RX_FILL, RX_HOLD} rx_state_e;

   // ---------------------------------------------------------------- TX path
   tx_state_e     tx_state_q, tx_state_d;
   logic [CW-1:0] ocnt_q, ocnt_d;
   logic [QW-1:0] hold_q [XW];
   logic          tx_load;
   logic          tx_last;

   assign tx_last = (ocnt_q == LAST);

   // TX next state: the final word handshake frees the holding register in the
   // same cycle, so a waiting vector reloads it without a bubble.
   always_comb begin
      tx_state_d  = tx_state_q;
      ocnt_d      = ocnt_q;
      vec_ready_o = 1'b0;
      nw_valid_o  = 1'b0;
      tx_load     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            vec_ready_o = 1'b1;
         end
         TX_SEND: begin
            nw_valid_o  = 1'b1;
            vec_ready_o = nw_ready_i & tx_last;
            if (nw_ready_i) begin
               if (tx_last) begin
                  tx_state_d = TX_IDLE;
                  ocnt_d     = '0;
               end else begin
                  ocnt_d = ocnt_q + 1'b1;
               end
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
         end
      endcase
      if (vec_valid_i && vec_ready_o) begin
         tx_load    = 1'b1;
         tx_state_d = TX_SEND;
         ocnt_d     = '0;
      end
   end

   // TX state and word counter registers
   always_ff @(posedge clk_nw or negedge rstn_nw) begin
      if (!rstn_nw) begin
         tx_state_q <= TX_IDLE;
         ocnt_q     <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         ocnt_q     <= ocnt_d;
      end
   end

   // Holding register: only the framed channels are captured; the rest stay 0
   always_ff @(posedge clk_nw or negedge rstn_nw) begin
      if (!rstn_nw) begin
         for (int i = 0; i < XW; i++) begin
            hold_q[i] <= '0;
         end
      end else if (tx_load) begin
         for (int i = 0; i < XW; i++) begin
            if (i < valid_chans) begin
               hold_q[i] <= vec_data_i[i];
            end
         end
      end
   end

   // The word on the wire is selected from state only, so it stays put under
   // backpressure; outside a frame the bus is driven to 0.
   assign nw_data_o = (tx_state_q == TX_SEND) ? hold_q[ocnt_q] : '0;

   // ---------------------------------------------------------------- RX path
   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] icnt_q, icnt_d;
   logic [QW-1:0] buf_q [XW];
   logic          rx_wr;

   // RX next state: in HOLD a word is only accepted together with the vector
   // consume, and icnt is 0 there, so that word lands in slot 0. With a single
   // channel per frame that word immediately completes the next frame.
   always_comb begin
      rx_state_d  = rx_state_q;
      icnt_d      = icnt_q;
      nw_ready_o  = 1'b1;
      vec_valid_o = 1'b0;
      rx_wr       = 1'b0;
      case (rx_state_q)
         RX_FILL: begin
            nw_ready_o = 1'b1;
         end
         RX_HOLD: begin
            vec_valid_o = 1'b1;
            nw_ready_o  = vec_ready_i;
            if (vec_ready_i) begin
               rx_state_d = RX_FILL;
            end
         end
         default: begin
            rx_state_d = RX_FILL;
         end
      endcase
      if (nw_valid_i && nw_ready_o) begin
         rx_wr = 1'b1;
         if (icnt_q == LAST) begin
            rx_state_d = RX_HOLD;
            icnt_d     = '0;
         end else begin
            icnt_d = icnt_q + 1'b1;
         end
      end
   end

   // RX state and word counter registers
   always_ff @(posedge clk_nw or negedge rstn_nw) begin
      if (!rstn_nw) begin
         rx_state_q <= RX_FILL;
         icnt_q     <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         icnt_q     <= icnt_d;
      end
   end

   // Assembly buffer: each accepted word goes to the slot selected by icnt
   always_ff @(posedge clk_nw or negedge rstn_nw) begin
      if (!rstn_nw) begin
         for (int i = 0; i < XW; i++) begin
            buf_q[i] <= '0;
         end
      end else if (rx_wr) begin
         for (int i = 0; i < XW; i++) begin
            if ((i < valid_chans) && (icnt_q == CW'(i))) begin
               buf_q[i] <= nw_data_i;
            end
         end
      end
   end

   // Output vector: framed channels while holding, zero everywhere else
   for (genvar gi = 0; gi < XW; gi++) begin : g_vec_out
      localparam bit USED = (gi < valid_chans);
      assign vec_data_o[gi] = (USED && (rx_state_q == RX_HOLD)) ? buf_q[gi] : '0;
   end

endmodule

// File: tb/tb_vec_stream_io.sv
// Directed and randomized bench for vec_stream_io: one instance framed at 4
// channels, one at 1 channel, sharing clock and reset.
module tb_vec_stream_io;

   localparam int QW = 8;
   localparam int XW = 8;

   typedef logic [XW-1:0][QW-1:0] vec_t;

   logic clk = 1'b0;
   logic rstn_nw = 1'b0;

   // index 0: valid_chans=4, index 1: valid_chans=1
   logic [1:0][XW-1:0][QW-1:0] vdi;
   logic [1:0]                 vvi;
   logic [1:0]                 vro;
   logic [1:0][QW-1:0]         ndo;
   logic [1:0]                 nvo;
   logic [1:0]                 nri;
   logic [1:0][QW-1:0]         ndi;
   logic [1:0]                 nvi;
   logic [1:0]                 nro;
   logic [1:0][XW-1:0][QW-1:0] vdo;
   logic [1:0]                 vvo;
   logic [1:0]                 vri;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   vec_stream_io #(.QW(QW), .XW(XW), .valid_chans(4)) u_dut4 (
      .clk_nw      (clk),
      .rstn_nw     (rstn_nw),
      .vec_data_i  (vdi[0]),
      .vec_valid_i (vvi[0]),
      .vec_ready_o (vro[0]),
      .nw_data_o   (ndo[0]),
      .nw_valid_o  (nvo[0]),
      .nw_ready_i  (nri[0]),
      .nw_data_i   (ndi[0]),
      .nw_valid_i  (nvi[0]),
      .nw_ready_o  (nro[0]),
      .vec_data_o  (vdo[0]),
      .vec_valid_o (vvo[0]),
      .vec_ready_i (vri[0])
   );

   vec_stream_io #(.QW(QW), .XW(XW), .valid_chans(1)) u_dut1 (
      .clk_nw      (clk),
      .rstn_nw     (rstn_nw),
      .vec_data_i  (vdi[1]),
      .vec_valid_i (vvi[1]),
      .vec_ready_o (vro[1]),
      .nw_data_o   (ndo[1]),
      .nw_valid_o  (nvo[1]),
      .nw_ready_i  (nri[1]),
      .nw_data_i   (ndi[1]),
      .nw_valid_i  (nvi[1]),
      .nw_ready_o  (nro[1]),
      .vec_data_o  (vdo[1]),
      .vec_valid_o (vvo[1]),
      .vec_ready_i (vri[1])
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic vec_t mk4(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d);
      vec_t v;
      v    = '0;
      v[0] = a;
      v[1] = b;
      v[2] = c;
      v[3] = d;
      return v;
   endfunction

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_nw_valid"},  nvo[0], 1'b0);
      chk({pfx, "_vec_valid"}, vvo[0], 1'b0);
      chk({pfx, "_vec_ready"}, vro[0], 1'b1);
      chk({pfx, "_nw_ready"},  nro[0], 1'b1);
      chk({pfx, "_nw_data"},   ndo[0], '0);
      chk({pfx, "_vec_data"},  vdo[0], '0);
   endtask

   // Random traffic on all four handshakes of instance k, then a drain phase
   // that completes any partial frames; a queue per direction is the reference.
   task automatic rand_run(input int k, input int cycles);
      logic [QW-1:0] txq[$];
      logic [QW-1:0] rxq[$];
      logic [QW-1:0] exp_w;
      int  vc;
      int  rx_sent;
      bit  tx_acc;
      bit  rx_acc;
      bit  drain;
      vc      = (k == 0) ? 4 : 1;
      rx_sent = 0;
      tx_acc  = 1'b0;
      rx_acc  = 1'b0;
      for (int cyc = 0; cyc < cycles + 60; cyc++) begin
         drain = (cyc >= cycles);
         @(negedge clk);
         // vector source: an offer stays unchanged until it is accepted
         if (!vvi[k] || tx_acc) begin
            vvi[k] = 1'b0;
            if (!drain && ($urandom_range(0, 1) == 1)) begin
               vvi[k] = 1'b1;
               for (int c = 0; c < XW; c++) vdi[k][c] = QW'($urandom);
            end
         end
         // word source
         if (!nvi[k] || rx_acc) begin
            nvi[k] = 1'b0;
            if (drain ? ((rx_sent % vc) != 0) : ($urandom_range(0, 1) == 1)) begin
               nvi[k] = 1'b1;
               ndi[k] = QW'($urandom);
            end
         end
         nri[k] = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
         vri[k] = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
         tx_acc = 1'b0;
         rx_acc = 1'b0;
         #1;
         chk($sformatf("rnd%0d_nw_valid", k), nvo[k], txq.size() != 0);
         chk($sformatf("rnd%0d_vec_valid", k), vvo[k], rxq.size() >= vc);
         // TX: word leaving this edge, then a vector entering this edge
         if (nvo[k] && nri[k]) begin
            chk($sformatf("rnd%0d_tx_expected", k), txq.size() != 0, 1'b1);
            if (txq.size() != 0) begin
               exp_w = txq.pop_front();
               chk($sformatf("rnd%0d_tx_word", k), ndo[k], exp_w);
            end
         end
         if (vvi[k] && vro[k]) begin
            for (int c = 0; c < vc; c++) txq.push_back(vdi[k][c]);
            tx_acc = 1'b1;
         end
         // RX: vector consumed this edge, then a word entering this edge
         if (vvo[k] && vri[k]) begin
            chk($sformatf("rnd%0d_rx_count", k), rxq.size() >= vc, 1'b1);
            if (rxq.size() >= vc) begin
               for (int c = 0; c < XW; c++) begin
                  exp_w = (c < vc) ? rxq[c] : '0;
                  chk($sformatf("rnd%0d_rx_ch%0d", k, c), vdo[k][c], exp_w);
               end
               for (int c = 0; c < vc; c++) void'(rxq.pop_front());
            end
         end
         if (nvi[k] && nro[k]) begin
            rxq.push_back(ndi[k]);
            rx_sent++;
            rx_acc = 1'b1;
         end
      end
      @(negedge clk);
      vvi[k] = 1'b0;
      nvi[k] = 1'b0;
      vri[k] = 1'b0;
      #1;
      chk($sformatf("rnd%0d_tx_drained", k), txq.size(), 0);
      chk($sformatf("rnd%0d_rx_drained", k), rxq.size(), 0);
      chk($sformatf("rnd%0d_end_vec_valid", k), vvo[k], 1'b0);
      $display("random run vc=%0d: %0d rx words exchanged", vc, rx_sent);
   endtask

   initial begin
      logic [7:0] exp_tx [4];
      vdi = '0; vvi = '0; nri = '0; ndi = '0; nvi = '0; vri = '0;

      // ---- reset state
      @(negedge clk);
      #1;
      chk_reset_outputs("rst");
      @(negedge clk);
      rstn_nw = 1'b1;

      // ---- TX basic: channels beyond the frame must never be emitted
      @(negedge clk);
      nri[0] = 1'b1;
      vdi[0] = mk4(8'h11, 8'h22, 8'h33, 8'h44);
      vdi[0][4] = 8'h55; vdi[0][5] = 8'h66; vdi[0][6] = 8'h77; vdi[0][7] = 8'h88;
      vvi[0] = 1'b1;
      #1;
      chk("txb_accept_ready", vro[0], 1'b1);
      exp_tx[0] = 8'h11; exp_tx[1] = 8'h22; exp_tx[2] = 8'h33; exp_tx[3] = 8'h44;
      for (int w = 0; w < 4; w++) begin
         @(negedge clk);
         vvi[0] = 1'b0;
         #1;
         chk($sformatf("txb_word%0d", w), {nvo[0], ndo[0]}, {1'b1, exp_tx[w]});
         chk($sformatf("txb_ready%0d", w), vro[0], (w == 3));
         $display("tx word %0d = %02h", w, ndo[0]);
      end
      @(negedge clk);
      #1;
      chk("txb_idle_after", nvo[0], 1'b0);

      // ---- TX backpressure on word 2, second vector in last-word cycle
      @(negedge clk);
      vdi[0] = mk4(8'h11, 8'h22, 8'h33, 8'h44);
      vvi[0] = 1'b1;
      nri[0] = 1'b1;
      #1;
      chk("txbp_accept", vro[0], 1'b1);
      @(negedge clk);
      vvi[0] = 1'b0;
      #1;
      chk("txbp_w0", ndo[0], 8'h11);
      @(negedge clk);
      #1;
      chk("txbp_w1", ndo[0], 8'h22);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         nri[0] = 1'b0;
         vdi[0] = mk4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
         vvi[0] = 1'b1;
         #1;
         chk($sformatf("txbp_stall%0d_valid", s), nvo[0], 1'b1);
         chk($sformatf("txbp_stall%0d_data", s), ndo[0], 8'h33);
         chk($sformatf("txbp_stall%0d_vready", s), vro[0], 1'b0);
      end
      @(negedge clk);
      nri[0] = 1'b1;
      #1;
      chk("txbp_w2", ndo[0], 8'h33);
      chk("txbp_w2_vready", vro[0], 1'b0);
      @(negedge clk);
      #1;
      chk("txbp_w3", ndo[0], 8'h44);
      chk("txbp_w3_vready", vro[0], 1'b1);
      exp_tx[0] = 8'hA0; exp_tx[1] = 8'hA1; exp_tx[2] = 8'hA2; exp_tx[3] = 8'hA3;
      for (int w = 0; w < 4; w++) begin
         @(negedge clk);
         vvi[0] = 1'b0;
         #1;
         chk($sformatf("txbb_word%0d", w), {nvo[0], ndo[0]}, {1'b1, exp_tx[w]});
         $display("tx back-to-back word %0d = %02h", w, ndo[0]);
      end
      @(negedge clk);
      #1;
      chk("txbb_idle_after", nvo[0], 1'b0);

      // ---- RX basic: consumer stalled
      vri[0] = 1'b0;
      for (int w = 1; w <= 4; w++) begin
         @(negedge clk);
         nvi[0] = 1'b1;
         ndi[0] = QW'(w);
         #1;
         chk($sformatf("rxb_ready%0d", w), nro[0], 1'b1);
         chk($sformatf("rxb_novalid%0d", w), vvo[0], 1'b0);
      end
      @(negedge clk);
      nvi[0] = 1'b0;
      #1;
      chk("rxb_vec_valid", vvo[0], 1'b1);
      chk("rxb_vec_data", vdo[0], mk4(8'd1, 8'd2, 8'd3, 8'd4));
      chk("rxb_nw_ready_held", nro[0], 1'b0);
      $display("rx vector = %h", vdo[0]);

      // ---- RX overlap: word 5 offered while held, taken with the consume
      @(negedge clk);
      nvi[0] = 1'b1;
      ndi[0] = 8'd5;
      #1;
      chk("rxo_blocked", nro[0], 1'b0);
      chk("rxo_still_valid", vvo[0], 1'b1);
      @(negedge clk);
      vri[0] = 1'b1;
      #1;
      chk("rxo_ready_follows", nro[0], 1'b1);
      chk("rxo_data_at_consume", vdo[0], mk4(8'd1, 8'd2, 8'd3, 8'd4));
      for (int w = 6; w <= 8; w++) begin
         @(negedge clk);
         vri[0] = 1'b0;
         ndi[0] = QW'(w);
         #1;
         chk($sformatf("rxo_fill%0d_valid", w), vvo[0], 1'b0);
         chk($sformatf("rxo_fill%0d_ready", w), nro[0], 1'b1);
      end
      @(negedge clk);
      nvi[0] = 1'b0;
      #1;
      chk("rxo_vec_valid", vvo[0], 1'b1);
      chk("rxo_vec_data", vdo[0], mk4(8'd5, 8'd6, 8'd7, 8'd8));
      $display("rx vector = %h", vdo[0]);
      @(negedge clk);
      vri[0] = 1'b1;
      @(negedge clk);
      vri[0] = 1'b0;
      #1;
      chk("rxo_consumed", vvo[0], 1'b0);

      // ---- reset mid-frame on both paths
      @(negedge clk);
      vdi[0] = mk4(8'h61, 8'h62, 8'h63, 8'h64);
      vvi[0] = 1'b1;
      nri[0] = 1'b1;
      nvi[0] = 1'b1;
      ndi[0] = 8'h71;
      @(negedge clk);
      vvi[0] = 1'b0;
      ndi[0] = 8'h72;
      #1;
      chk("rstm_w0", ndo[0], 8'h61);
      @(negedge clk);
      nvi[0] = 1'b0;
      rstn_nw = 1'b0;
      #1;
      chk_reset_outputs("rstm");
      @(negedge clk);
      @(negedge clk);
      rstn_nw = 1'b1;
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rstm_no_word%0d", s), nvo[0], 1'b0);
      end
      for (int w = 0; w < 4; w++) begin
         @(negedge clk);
         nvi[0] = 1'b1;
         ndi[0] = 8'h51 + 8'(w);
      end
      @(negedge clk);
      nvi[0] = 1'b0;
      #1;
      chk("rstm_rx_valid", vvo[0], 1'b1);
      chk("rstm_rx_data", vdo[0], mk4(8'h51, 8'h52, 8'h53, 8'h54));
      @(negedge clk);
      vri[0] = 1'b1;
      @(negedge clk);
      vri[0] = 1'b0;

      // ---- concurrent random traffic, 4-channel and 1-channel framing
      rand_run(0, 400);
      rand_run(1, 400);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
